spi_mem_target: RTL



---
 rtl/spi_mem_pkg.sv | 36 +++
 rtl/spi_edge_sync.sv | 78 +++++++
 rtl/spi_mem_target.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg
// Shared definitions for the SPI memory target and its helpers:
//   - flash-style opcode values
//   - FSM state encoding for the command decoder
//   - status register bit positions and a helper that assembles the status byte
// Optional build macro used by spi_mem_target: SPI_MEM_TARGET_WEL_EN.
package spi_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  // Status register layout: bit 0 is write-in-progress (always 0 here,
  // writes complete in one cycle), bit 1 is the write-enable latch.
  localparam int STATUS_WIP_BIT = 0;
  localparam int STATUS_WEL_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_WEL_BIT] = wel;
    return s;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync
// Brings the asynchronous SPI pins (CSn, SCK, MOSI) into the clk domain
// through SYNC_STAGES flops each (use at least 2) and derives single-cycle
// edge pulses from the last two synchronized samples.
// Ports:
//   clk, rst_n         system clock, synchronous active-low reset
//   csn, sck, mosi     raw SPI pins
//   cs_n_sync          synchronized chip select level
//   mosi_sync          synchronized MOSI, aligned with the SCK edge pulses
//   sck_rise, sck_fall one-cycle pulses on synchronized SCK edges
//   cs_fall, cs_rise   one-cycle pulses on synchronized CSn edges
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic csn,
  input  logic sck,
  input  logic mosi,
  output logic cs_n_sync,
  output logic mosi_sync,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] cs_pipe_reg;
  logic [SYNC_STAGES-1:0] sck_pipe_reg;
  logic [SYNC_STAGES-1:0] mosi_pipe_reg;
  logic [SYNC_STAGES-1:0] cs_pipe_next;
  logic [SYNC_STAGES-1:0] sck_pipe_next;
  logic [SYNC_STAGES-1:0] mosi_pipe_next;
  logic                   cs_prev_reg;
  logic                   sck_prev_reg;

  // Each stage takes the pin (first stage) or the previous stage.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign cs_pipe_next[gi]   = csn;
        assign sck_pipe_next[gi]  = sck;
        assign mosi_pipe_next[gi] = mosi;
      end else begin : g_next
        assign cs_pipe_next[gi]   = cs_pipe_reg[gi-1];
        assign sck_pipe_next[gi]  = sck_pipe_reg[gi-1];
        assign mosi_pipe_next[gi] = mosi_pipe_reg[gi-1];
      end
    end
  endgenerate

  // CSn resets to the deasserted level so leaving reset never looks like
  // the start of a transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_pipe_reg   <= '1;
      sck_pipe_reg  <= '0;
      mosi_pipe_reg <= '0;
      cs_prev_reg   <= 1'b1;
      sck_prev_reg  <= 1'b0;
    end else begin
      cs_pipe_reg   <= cs_pipe_next;
      sck_pipe_reg  <= sck_pipe_next;
      mosi_pipe_reg <= mosi_pipe_next;
      cs_prev_reg   <= cs_pipe_reg[SYNC_STAGES-1];
      sck_prev_reg  <= sck_pipe_reg[SYNC_STAGES-1];
    end
  end

  assign cs_n_sync = cs_pipe_reg[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe_reg[SYNC_STAGES-1];
  assign sck_rise  =  sck_pipe_reg[SYNC_STAGES-1] & ~sck_prev_reg;
  assign sck_fall  = ~sck_pipe_reg[SYNC_STAGES-1] &  sck_prev_reg;
  assign cs_fall   = ~cs_pipe_reg[SYNC_STAGES-1]  &  cs_prev_reg;
  assign cs_rise   =  cs_pipe_reg[SYNC_STAGES-1]  & ~cs_prev_reg;

endmodule

// File: rtl/spi_mem_target.sv
// spi_mem_target
// SPI mode-0 responder serving flash-style commands (READ 03, WRITE 02,
// RDSR 05, WREN 06, WRDI 04) from an internal byte memory. All logic runs in
// the clk domain, oversampling SCK (clk must be >= 8x SCK).
// Build option: define SPI_MEM_TARGET_WEL_EN to make WRITE require the
// write-enable latch (and clear it when a WRITE transaction ends).
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   CSn/SCK/MOSI SPI inputs from the initiator
//   MISO         read data, MSB first, changes after SCK falls
//   MISO_oe      high while the target drives read/status data
//   wr_strobe    one-cycle pulse per committed byte, with wr_addr/wr_data
//   busy         synchronized chip select is asserted
module spi_mem_target
  import spi_mem_pkg::*;
#(
  parameter int MEM_DEPTH   = 4096,
  parameter int ADDR_BYTES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         CSn,
  input  logic                         SCK,
  input  logic                         MOSI,
  output logic                         MISO,
  output logic                         MISO_oe,
  output logic                         wr_strobe,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         busy
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int ABC_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [ABC_W-1:0] LAST_ADDR_BYTE = ABC_W'(ADDR_BYTES - 1);

  // Synchronized pins and edge pulses
  logic cs_n_sync;
  logic mosi_sync;
  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .csn      (CSn),
    .sck      (SCK),
    .mosi     (MOSI),
    .cs_n_sync(cs_n_sync),
    .mosi_sync(mosi_sync),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise)
  );

  // FSM / datapath state
  state_t            state_reg;
  logic [2:0]        bit_cnt_reg;
  logic [6:0]        shift_reg;       // the 7 bits received before the current one
  logic [7:0]        opcode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ABC_W-1:0]  addr_byte_cnt_reg;
  logic [2:0]        out_cnt_reg;
  logic [6:0]        tx_shift_reg;
  logic              rdsr_reg;
  logic              wel_reg;
  logic              miso_reg;
  logic              miso_oe_reg;
  logic              wr_strobe_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic              busy_reg;

  // Memory
  logic [7:0]        mem [MEM_DEPTH];
  logic [7:0]        rd_data_reg;

  // Combinational helpers
  logic [7:0]        rx_byte;
  logic              byte_done;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] addr_inc;
  logic              addr_last;
  logic              rd_byte_end;
  logic              write_ok;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        load_byte;

`ifdef SPI_MEM_TARGET_WEL_EN
  assign write_ok = wel_reg;
`else
  assign write_ok = 1'b1;
`endif

  always_comb begin
    // The byte completed by this rising edge, including the bit just sampled.
    rx_byte     = {shift_reg, mosi_sync};
    // A chip-select release on the same cycle as the 8th rise wins, so the
    // byte is discarded.
    byte_done   = sck_rise && !cs_rise && (state_reg != ST_IDLE) && (bit_cnt_reg == 3'd7);
    // Shifting left through an ADDR_W-wide register drops the upper wire
    // address bits, giving the modulo-MEM_DEPTH address for free.
    addr_next   = {addr_reg[ADDR_W-2:0], mosi_sync};
    addr_inc    = addr_reg + ADDR_W'(1);
    addr_last   = (state_reg == ST_ADDR) && byte_done && (addr_byte_cnt_reg == LAST_ADDR_BYTE);
    rd_byte_end = (state_reg == ST_RD_DATA) && sck_fall && !cs_rise && (out_cnt_reg == 3'd7);
    mem_we      = (state_reg == ST_WR_DATA) && byte_done && write_ok;
    // First byte is fetched as the last address bit arrives; later bytes are
    // prefetched as bit 0 of the current byte goes out.
    mem_re      = (addr_last && (opcode_reg != OP_WRITE)) || (rd_byte_end && !rdsr_reg);
    mem_raddr   = addr_last ? addr_next : addr_inc;
    load_byte   = rdsr_reg ? status_byte(wel_reg) : rd_data_reg;
  end

  // Block RAM: no reset, registered read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_reg] <= rx_byte;
    end
    if (mem_re) begin
      rd_data_reg <= mem[mem_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      bit_cnt_reg       <= 3'd0;
      shift_reg         <= 7'd0;
      opcode_reg        <= 8'h00;
      addr_reg          <= '0;
      addr_byte_cnt_reg <= '0;
      out_cnt_reg       <= 3'd0;
      tx_shift_reg      <= 7'd0;
      rdsr_reg          <= 1'b0;
      wel_reg           <= 1'b0;
      miso_reg          <= 1'b0;
      miso_oe_reg       <= 1'b0;
      wr_strobe_reg     <= 1'b0;
      wr_addr_reg       <= '0;
      wr_data_reg       <= 8'h00;
      busy_reg          <= 1'b0;
    end else begin
      wr_strobe_reg <= 1'b0;
      busy_reg      <= ~cs_n_sync;

      if (cs_rise) begin
        // End of transaction from any state; any partial byte is dropped.
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= 3'd0;
        miso_reg    <= 1'b0;
        miso_oe_reg <= 1'b0;
`ifdef SPI_MEM_TARGET_WEL_EN
        if ((state_reg != ST_IDLE) && (opcode_reg == OP_WRITE)) begin
          wel_reg <= 1'b0;
        end
`endif
      end else begin
        if ((state_reg != ST_IDLE) && sck_rise) begin
          shift_reg   <= rx_byte[6:0];
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end

        case (state_reg)
          ST_IDLE: begin
            if (cs_fall) begin
              state_reg   <= ST_CMD;
              bit_cnt_reg <= 3'd0;
              opcode_reg  <= 8'h00;
              rdsr_reg    <= 1'b0;
            end
          end

          ST_CMD: begin
            if (byte_done) begin
              opcode_reg <= rx_byte;
              case (rx_byte)
                OP_READ, OP_WRITE: begin
                  state_reg         <= ST_ADDR;
                  addr_reg          <= '0;
                  addr_byte_cnt_reg <= '0;
                end
                OP_RDSR: begin
                  state_reg   <= ST_RD_DATA;
                  rdsr_reg    <= 1'b1;
                  out_cnt_reg <= 3'd0;
                end
                OP_WREN: begin
                  wel_reg   <= 1'b1;
                  state_reg <= ST_IGNORE;
                end
                OP_WRDI: begin
                  wel_reg   <= 1'b0;
                  state_reg <= ST_IGNORE;
                end
                default: state_reg <= ST_IGNORE;
              endcase
            end
          end

          ST_ADDR: begin
            if (sck_rise) begin
              addr_reg <= addr_next;
            end
            if (byte_done) begin
              if (addr_byte_cnt_reg == LAST_ADDR_BYTE) begin
                state_reg   <= (opcode_reg == OP_WRITE) ? ST_WR_DATA : ST_RD_DATA;
                out_cnt_reg <= 3'd0;
              end else begin
                addr_byte_cnt_reg <= addr_byte_cnt_reg + ABC_W'(1);
              end
            end
          end

          ST_RD_DATA: begin
            if (sck_fall) begin
              miso_oe_reg <= 1'b1;
              out_cnt_reg <= out_cnt_reg + 3'd1;
              if (out_cnt_reg == 3'd0) begin
                // Start of a byte: MSB straight from the preloaded value.
                miso_reg     <= load_byte[7];
                tx_shift_reg <= load_byte[6:0];
              end else begin
                miso_reg     <= tx_shift_reg[6];
                tx_shift_reg <= {tx_shift_reg[5:0], 1'b0};
              end
              if ((out_cnt_reg == 3'd7) && !rdsr_reg) begin
                addr_reg <= addr_inc;
              end
            end
          end

          ST_WR_DATA: begin
            if (byte_done && write_ok) begin
              wr_strobe_reg <= 1'b1;
              wr_addr_reg   <= addr_reg;
              wr_data_reg   <= rx_byte;
              addr_reg      <= addr_inc;
            end
          end

          ST_IGNORE: begin
            miso_reg <= 1'b0;
          end

          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign MISO      = miso_reg;
  assign MISO_oe   = miso_oe_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign busy      = busy_reg;

endmodule
